// File: rtl/fp_mult_add_responder.sv
// Single-precision multiply/add responder for the postfix term accumulator.
// Fixed-latency FSM; results are zero except on their one-cycle ready pulse so buses can be OR-combined.
module fp_mult_add_responder #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mult_start,
  input  logic                  add_start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] mult_result,
  output logic [DATA_WIDTH-1:0] add_result,
  output logic                  mult_data_ready,
  output logic                  add_data_ready,
  output logic                  busy
);

  localparam int MW = MANTISSA_LEN + 1;        // mantissa with hidden bit
  localparam int PW = 2 * MW;
  localparam int EW = EXP_LEN + 2;             // headroom for exponent sums
  localparam int LW = $clog2(MW + 1);
  localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_LEN) - 1);
  localparam logic [DATA_WIDTH-2:0] INF_MAG = {{EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, M_UNPACK, M_MUL, M_NORM, M_PACK,
    A_UNPACK, A_ALIGN, A_SUM, A_NORM, A_PACK
  } state_e;

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic                    sa_q, sa_d, sb_q, sb_d;
  logic [EXP_LEN-1:0]      ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0]           ma_q, ma_d, mb_q, mb_d;
  logic                    za_q, za_d, zb_q, zb_d, ia_q, ia_d, ib_q, ib_d;
  logic [MW:0]             prod_q, prod_d;
  logic                    sum_s_q, sum_s_d, eff_sub_q, eff_sub_d;
  logic [EXP_LEN-1:0]      big_e_q, big_e_d;
  logic [MW-1:0]           big_m_q, big_m_d, small_m_q, small_m_d;
  logic [MW:0]             sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [DATA_WIDTH-1:0]   mult_result_q, mult_result_d, add_result_q, add_result_d;
  logic                    mult_rdy_q, mult_rdy_d, add_rdy_q, add_rdy_d;

  logic                    swap;
  logic [EXP_LEN-1:0]      diff;
  logic [EW-1:0]           m_exp, a_exp_up;
  logic [LW-1:0]           lzc;

  function automatic logic [LW-1:0] lzc_fn(input logic [MW-1:0] v);
    lzc_fn = LW'(MW);
    for (int i = 0; i < MW; i++) if (v[i]) lzc_fn = LW'(MW - 1 - i);
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d       = state_q;
    busy_d        = (state_q != IDLE);
    opa_d = opa_q;  opb_d = opb_q;
    sa_d = sa_q;  sb_d = sb_q;  ea_d = ea_q;  eb_d = eb_q;
    ma_d = ma_q;  mb_d = mb_q;  za_d = za_q;  zb_d = zb_q;  ia_d = ia_q;  ib_d = ib_q;
    prod_d = prod_q;  sum_s_d = sum_s_q;  eff_sub_d = eff_sub_q;
    big_e_d = big_e_q;  big_m_d = big_m_q;  small_m_d = small_m_q;
    sum_d = sum_q;  res_d = res_q;
    mult_result_d = '0;  add_result_d = '0;
    mult_rdy_d    = 1'b0;  add_rdy_d = 1'b0;
    swap     = ({eb_q, mb_q} > {ea_q, ma_q});
    diff     = swap ? (eb_q - ea_q) : (ea_q - eb_q);
    m_exp    = EW'(ea_q) + EW'(eb_q) + EW'(prod_q[MW]);
    a_exp_up = EW'(big_e_q) + EW'(1);
    lzc      = lzc_fn(sum_q[MW-1:0]);

    case (state_q)
      IDLE: begin
        if (!busy_q && (mult_start || add_start)) begin
          opa_d   = operand_a;
          opb_d   = operand_b;
          state_d = mult_start ? M_UNPACK : A_UNPACK;
        end
      end
      M_UNPACK, A_UNPACK: begin
        sa_d = opa_q[DATA_WIDTH-1];
        sb_d = opb_q[DATA_WIDTH-1];
        ea_d = opa_q[DATA_WIDTH-2 -: EXP_LEN];
        eb_d = opb_q[DATA_WIDTH-2 -: EXP_LEN];
        za_d = (ea_d == '0);
        zb_d = (eb_d == '0);
        ia_d = (&ea_d);
        ib_d = (&eb_d);
        ma_d = za_d ? '0 : {1'b1, opa_q[MANTISSA_LEN-1:0]};
        mb_d = zb_d ? '0 : {1'b1, opb_q[MANTISSA_LEN-1:0]};
        state_d = (state_q == M_UNPACK) ? M_MUL : A_ALIGN;
      end
      M_MUL: begin
        // Only the bits at or above the truncation point are kept.
        prod_d  = (MW+1)'((PW'(ma_q) * PW'(mb_q)) >> MANTISSA_LEN);
        state_d = M_NORM;
      end
      M_NORM: begin
        if (za_q || zb_q)               res_d = {sa_q ^ sb_q, {(DATA_WIDTH-1){1'b0}}};
        else if (ia_q || ib_q)          res_d = {sa_q ^ sb_q, INF_MAG};
        else if (m_exp >= BIAS + EXP_MAX) res_d = {sa_q ^ sb_q, INF_MAG};
        else if (m_exp <= BIAS)         res_d = {sa_q ^ sb_q, {(DATA_WIDTH-1){1'b0}}};
        else res_d = {sa_q ^ sb_q, EXP_LEN'(m_exp - BIAS),
                      prod_q[MW] ? prod_q[MW-1:1] : prod_q[MW-2:0]};
        state_d = M_PACK;
      end
      M_PACK: begin
        mult_result_d = res_q;
        mult_rdy_d    = 1'b1;
        state_d       = IDLE;
      end
      A_ALIGN: begin
        big_e_d   = swap ? eb_q : ea_q;
        big_m_d   = swap ? mb_q : ma_q;
        small_m_d = (diff > EXP_LEN'(MW)) ? '0 : ((swap ? ma_q : mb_q) >> diff);
        sum_s_d   = swap ? sb_q : sa_q;
        eff_sub_d = sa_q ^ sb_q;
        state_d   = A_SUM;
      end
      A_SUM: begin
        sum_d   = eff_sub_q ? ({1'b0, big_m_q} - {1'b0, small_m_q})
                            : ({1'b0, big_m_q} + {1'b0, small_m_q});
        state_d = A_NORM;
      end
      A_NORM: begin
        if (ia_q && ib_q)       res_d = opa_q;
        else if (ia_q)          res_d = {sa_q, INF_MAG};
        else if (ib_q)          res_d = {sb_q, INF_MAG};
        else if (zb_q)          res_d = opa_q;
        else if (za_q)          res_d = opb_q;
        else if (sum_q[MW]) begin
          if (a_exp_up >= EXP_MAX) res_d = {sum_s_q, INF_MAG};
          else res_d = {sum_s_q, EXP_LEN'(a_exp_up), sum_q[MW-1:1]};
        end
        else if (sum_q == '0)   res_d = '0;
        else if (EW'(big_e_q) <= EW'(lzc)) res_d = {sum_s_q, {(DATA_WIDTH-1){1'b0}}};
        else res_d = {sum_s_q, EXP_LEN'(EW'(big_e_q) - EW'(lzc)),
                      MANTISSA_LEN'(sum_q[MW-1:0] << lzc)};
        state_d = A_PACK;
      end
      A_PACK: begin
        add_result_d = res_q;
        add_rdy_d    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;  busy_q <= 1'b0;
      opa_q <= '0;  opb_q <= '0;
      sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;
      ma_q <= '0;  mb_q <= '0;  za_q <= 1'b0;  zb_q <= 1'b0;  ia_q <= 1'b0;  ib_q <= 1'b0;
      prod_q <= '0;  sum_s_q <= 1'b0;  eff_sub_q <= 1'b0;
      big_e_q <= '0;  big_m_q <= '0;  small_m_q <= '0;  sum_q <= '0;  res_q <= '0;
      mult_result_q <= '0;  add_result_q <= '0;  mult_rdy_q <= 1'b0;  add_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;  busy_q <= busy_d;
      opa_q <= opa_d;  opb_q <= opb_d;
      sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;
      ma_q <= ma_d;  mb_q <= mb_d;  za_q <= za_d;  zb_q <= zb_d;  ia_q <= ia_d;  ib_q <= ib_d;
      prod_q <= prod_d;  sum_s_q <= sum_s_d;  eff_sub_q <= eff_sub_d;
      big_e_q <= big_e_d;  big_m_q <= big_m_d;  small_m_q <= small_m_d;  sum_q <= sum_d;  res_q <= res_d;
      mult_result_q <= mult_result_d;  add_result_q <= add_result_d;
      mult_rdy_q <= mult_rdy_d;  add_rdy_q <= add_rdy_d;
    end
  end

  assign mult_result     = mult_result_q;
  assign add_result      = add_result_q;
  assign mult_data_ready = mult_rdy_q;
  assign add_data_ready  = add_rdy_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_fp_mult_add_responder.sv
// Directed bench for fp_mult_add_responder: hand-computed IEEE results, latency, busy window,
// start collision/overlap, mid-operation reset and back-to-back issue.
module tb_fp_mult_add_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0, add_start = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [31:0] mult_result, add_result;
  logic        mult_data_ready, add_data_ready, busy;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mult_add_responder dut (
    .clock(clock), .reset(reset),
    .mult_start(mult_start), .add_start(add_start),
    .operand_a(operand_a), .operand_b(operand_b),
    .mult_result(mult_result), .add_result(add_result),
    .mult_data_ready(mult_data_ready), .add_data_ready(add_data_ready),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a start at a negedge; it is sampled at the next rising edge (T0), then operands are scrambled.
  task automatic issue(input logic m, input logic ad, input logic [31:0] a, input logic [31:0] b);
    mult_start = m;  add_start = ad;  operand_a = a;  operand_b = b;
    @(posedge clock);
    #1;
    mult_start = 1'b0;  add_start = 1'b0;
    operand_a = 32'hA5A5_A5A5;  operand_b = 32'h5A5A_5A5A;
  endtask

  // Observe cycles T0+0..T0+win at the falling edge; optionally inject an add start after cycle inj_k.
  task automatic watch(input int win, input int inj_k,
                       output int mcnt, output int acnt, output int mcyc, output int acyc,
                       output int leak, output int brise, output int bfall,
                       output logic [31:0] mres, output logic [31:0] ares);
    mcnt = 0; acnt = 0; mcyc = -1; acyc = -1; leak = 0; brise = -1; bfall = -1;
    mres = '0; ares = '0;
    for (int k = 0; k <= win; k++) begin
      @(negedge clock);
      if (mult_data_ready) begin
        mcnt++;  if (mcyc < 0) mcyc = k;  mres = mult_result;
      end else if (mult_result != 0) leak++;
      if (add_data_ready) begin
        acnt++;  if (acyc < 0) acyc = k;  ares = add_result;
      end else if (add_result != 0) leak++;
      if (busy && brise < 0) brise = k;
      if (!busy && brise >= 0 && bfall < 0) bfall = k;
      if (k == inj_k) begin
        add_start = 1'b1;  operand_a = 32'h3F80_0000;  operand_b = 32'h3F80_0000;
      end else if (k == inj_k + 1) add_start = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic ad,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int win, input int inj_k);
    int mcnt, acnt, mcyc, acyc, leak, brise, bfall, lat;
    logic [31:0] mres, ares;
    lat = m ? 4 : 5;
    issue(m, ad, a, b);
    watch(win, inj_k, mcnt, acnt, mcyc, acyc, leak, brise, bfall, mres, ares);
    check({tag, ".mult_pulses"}, 32'(mcnt), m ? 32'd1 : 32'd0);
    check({tag, ".add_pulses"},  32'(acnt), m ? 32'd0 : 32'd1);
    check({tag, ".latency"},     32'(m ? mcyc : acyc), 32'(lat));
    check({tag, ".result"},      m ? mres : ares, exp_res);
    check({tag, ".zero_outside"}, 32'(leak), 32'd0);
    check({tag, ".busy_rise"},   32'(brise), 32'd1);
    check({tag, ".busy_fall"},   32'(bfall), 32'(lat + 1));
  endtask

  initial begin
    int mcnt, acnt, mcyc, acyc, leak, brise, bfall;
    logic [31:0] mres, ares;

    repeat (2) @(posedge clock);
    #1;
    check("reset.flags", {29'd0, busy, mult_data_ready, add_data_ready}, 32'd0);
    check("reset.mult_result", mult_result, 32'd0);
    check("reset.add_result", add_result, 32'd0);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);

    // Consecutive run_op calls issue in the cycle busy falls, so each is also a back-to-back start.
    run_op("mul_3x2.5",    1, 0, 32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 5, -1);
    run_op("mul_-2x3",     1, 0, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 5, -1);
    run_op("mul_1.5x1.5",  1, 0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5, -1);
    run_op("mul_ovf",      1, 0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 5, -1);
    run_op("mul_unf",      1, 0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5, -1);
    run_op("mul_0xninf",   1, 0, 32'h0000_0000, 32'hFF80_0000, 32'h8000_0000, 5, -1);
    run_op("add_1+2",      0, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6, -1);
    run_op("add_1-1",      0, 1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 6, -1);
    run_op("add_trunc",    0, 1, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 6, -1);
    run_op("add_carry",    0, 1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000, 6, -1);
    run_op("add_3-2",      0, 1, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 6, -1);
    run_op("add_1-2",      0, 1, 32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000, 6, -1);
    run_op("add_zero_a",   0, 1, 32'h0000_0000, 32'hC049_0FDB, 32'hC049_0FDB, 6, -1);
    run_op("add_inf_both", 0, 1, 32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 6, -1);
    run_op("add_inf_b",    0, 1, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 6, -1);
    run_op("collision",    1, 1, 32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 10, -1);
    run_op("overlap",      1, 0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 10, 1);

    // Reset two cycles into an add must abort it with no ready pulse.
    issue(0, 1, 32'h3F80_0000, 32'h4000_0000);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("abort.busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort.flags", {29'd0, busy, mult_data_ready, add_data_ready}, 32'd0);
    check("abort.results", mult_result | add_result, 32'd0);
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    watch(8, -1, mcnt, acnt, mcyc, acyc, leak, brise, bfall, mres, ares);
    check("abort.no_pulse", 32'(mcnt + acnt), 32'd0);
    check("abort.no_busy", 32'(brise), 32'hFFFF_FFFF);

    run_op("post_reset_mul", 1, 0, 32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 5, -1);
    run_op("b2b_add",        0, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 6, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
